// File: rtl/tdd_frame_scheduler_if.sv
// rtl/tdd_frame_scheduler_if.sv - register-side configuration and frame-adjust bundle for the TDD frame scheduler
//
// frame_len    frame length in samples (quasi-static)
// tstart/tend  TX window [tstart, tend) in samples
// rstart/rend  RX window [rstart, rend) in samples
// frame_adj    signed one-shot frame length correction
// adj_req      single-cycle pulse requesting frame_adj
// adj_pending  high while an adjust waits for the next frame start
// master: register space side, slave: scheduler side
interface tdd_frame_scheduler_if #(
    parameter int CNT_W = 24
);
    logic [CNT_W-1:0] frame_len;
    logic [CNT_W-1:0] tstart;
    logic [CNT_W-1:0] tend;
    logic [CNT_W-1:0] rstart;
    logic [CNT_W-1:0] rend;
    logic [CNT_W-1:0] frame_adj;
    logic             adj_req;
    logic             adj_pending;

    modport master (
        output frame_len, tstart, tend, rstart, rend, frame_adj, adj_req,
        input  adj_pending
    );

    modport slave (
        input  frame_len, tstart, tend, rstart, rend, frame_adj, adj_req,
        output adj_pending
    );
endinterface

// File: rtl/tdd_frame_scheduler.sv
// rtl/tdd_frame_scheduler.sv - TDD frame sequencer: sample counter, TX/RX window decode and RF gate drive
//
// clk        sample-domain clock
// rst_n      synchronous active-low reset
// ce         sample strobe; the frame counter advances only on ce
// en         TDD mode enable
// cfg        configuration / adjust bundle (slave side)
// frame_cnt  current sample index in the frame
// frame_num  frames started since the last entry to RUN
// frame_sync one-clk pulse at each frame start
// tx_en, tx_rx, pa_en, rf_sw  TX window gates
// rx_en      RX window gate, suppressed while TX is active
// conflict   sticky TX/RX window overlap flag
module tdd_frame_scheduler #(
    parameter int CNT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  en,
    tdd_frame_scheduler_if.slave  cfg,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [31:0]           frame_num,
    output logic                  frame_sync,
    output logic                  tx_en,
    output logic                  rx_en,
    output logic                  tx_rx,
    output logic                  pa_en,
    output logic                  rf_sw,
    output logic                  conflict
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;

    logic [CNT_W-1:0] len_sh;
    logic [CNT_W-1:0] tstart_sh;
    logic [CNT_W-1:0] tend_sh;
    logic [CNT_W-1:0] rstart_sh;
    logic [CNT_W-1:0] rend_sh;
    logic [CNT_W-1:0] adj_sh;
    logic [CNT_W-1:0] adj_val;
    logic             adj_pend_q;

    logic signed [CNT_W:0] len_sum;
    logic [CNT_W:0]   l_eff;
    logic [CNT_W:0]   l_last;
    logic             wrap;

    logic             start;
    logic             advance;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] ts_n;
    logic [CNT_W-1:0] te_n;
    logic [CNT_W-1:0] rs_n;
    logic [CNT_W-1:0] re_n;
    logic             txw;
    logic             rxw;

    // Effective length of the running frame; anything that comes out
    // non-positive is clamped to a one-sample frame.
    assign len_sum = $signed({1'b0, len_sh}) + $signed({adj_sh[CNT_W-1], adj_sh});
    assign l_eff   = (len_sum[CNT_W] || (len_sum == '0)) ? {{CNT_W{1'b0}}, 1'b1}
                                                         : $unsigned(len_sum);
    assign l_last  = l_eff - (CNT_W+1)'(1);
    assign wrap    = ({1'b0, frame_cnt} == l_last);

    always_comb begin
        start   = 1'b0;
        advance = 1'b0;
        cnt_nxt = frame_cnt;
        if (state == IDLE) begin
            if (en && ce) begin
                start   = 1'b1;
                advance = 1'b1;
                cnt_nxt = '0;
            end
        end else if (ce) begin
            advance = 1'b1;
            if (wrap) begin
                start   = 1'b1;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = frame_cnt + CNT_W'(1);
            end
        end
    end

    // Windows are decoded from the values the registers are about to take,
    // so on a frame start the freshly sampled window bounds apply to sample 0.
    assign ts_n = start ? cfg.tstart : tstart_sh;
    assign te_n = start ? cfg.tend   : tend_sh;
    assign rs_n = start ? cfg.rstart : rstart_sh;
    assign re_n = start ? cfg.rend   : rend_sh;

    assign txw = (cnt_nxt >= ts_n) && (cnt_nxt < te_n);
    assign rxw = (cnt_nxt >= rs_n) && (cnt_nxt < re_n);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            frame_num  <= '0;
            frame_sync <= 1'b0;
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            tx_rx      <= 1'b0;
            pa_en      <= 1'b0;
            rf_sw      <= 1'b0;
            conflict   <= 1'b0;
            len_sh     <= '0;
            tstart_sh  <= '0;
            tend_sh    <= '0;
            rstart_sh  <= '0;
            rend_sh    <= '0;
            adj_sh     <= '0;
            adj_val    <= '0;
            adj_pend_q <= 1'b0;
        end else if (state == RUN && !en) begin
            // Disable drops every gate immediately, independent of ce.
            state      <= IDLE;
            frame_cnt  <= '0;
            frame_num  <= '0;
            frame_sync <= 1'b0;
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            tx_rx      <= 1'b0;
            pa_en      <= 1'b0;
            rf_sw      <= 1'b0;
            conflict   <= 1'b0;
            adj_pend_q <= 1'b0;
        end else begin
            frame_sync <= start;
            if (advance) begin
                frame_cnt <= cnt_nxt;
                tx_en     <= txw;
                tx_rx     <= txw;
                pa_en     <= txw;
                rf_sw     <= txw;
                rx_en     <= rxw & ~txw;
                if (txw && rxw) begin
                    conflict <= 1'b1;
                end
            end
            if (start) begin
                state     <= RUN;
                frame_num <= (state == IDLE) ? 32'd0 : frame_num + 32'd1;
                len_sh    <= cfg.frame_len;
                tstart_sh <= cfg.tstart;
                tend_sh   <= cfg.tend;
                rstart_sh <= cfg.rstart;
                rend_sh   <= cfg.rend;
                adj_sh    <= adj_pend_q ? adj_val : '0;
            end
            // A request arriving on a frame-start edge is kept for the
            // following frame rather than consumed by this one.
            if (cfg.adj_req) begin
                adj_val    <= cfg.frame_adj;
                adj_pend_q <= 1'b1;
            end else if (start) begin
                adj_pend_q <= 1'b0;
            end
        end
    end

    assign cfg.adj_pending = adj_pend_q;

endmodule

// File: tb/tb_tdd_frame_scheduler.sv
// tb/tb_tdd_frame_scheduler.sv - directed self-checking bench for tdd_frame_scheduler
module tb_tdd_frame_scheduler;
    localparam int CNT_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ce;
    logic             en;
    logic [CNT_W-1:0] frame_cnt;
    logic [31:0]      frame_num;
    logic             frame_sync;
    logic             tx_en;
    logic             rx_en;
    logic             tx_rx;
    logic             pa_en;
    logic             rf_sw;
    logic             conflict;

    int checks = 0;
    int errors = 0;
    int c;
    int txc;

    tdd_frame_scheduler_if #(.CNT_W(CNT_W)) cfg_if ();

    tdd_frame_scheduler #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .en         (en),
        .cfg        (cfg_if),
        .frame_cnt  (frame_cnt),
        .frame_num  (frame_num),
        .frame_sync (frame_sync),
        .tx_en      (tx_en),
        .rx_en      (rx_en),
        .tx_rx      (tx_rx),
        .pa_en      (pa_en),
        .rf_sw      (rf_sw),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_gates(input string tag, input logic tx_exp, input logic rx_exp);
        chk({tag, "_tx_en"}, tx_en, tx_exp);
        chk({tag, "_tx_rx"}, tx_rx, tx_exp);
        chk({tag, "_pa_en"}, pa_en, tx_exp);
        chk({tag, "_rf_sw"}, rf_sw, tx_exp);
        chk({tag, "_rx_en"}, rx_en, rx_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ce    = 1'b0;
        cfg_if.frame_len = 24'd10;
        cfg_if.tstart    = 24'd2;
        cfg_if.tend      = 24'd5;
        cfg_if.rstart    = 24'd6;
        cfg_if.rend      = 24'd9;
        cfg_if.frame_adj = 24'd0;
        cfg_if.adj_req   = 1'b0;
        ticks(2);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_num", frame_num, 0);
        chk("rst_sync", frame_sync, 0);
        chk_gates("rst", 1'b0, 1'b0);
        chk("rst_conflict", conflict, 0);
        chk("rst_pending", cfg_if.adj_pending, 0);

        rst_n = 1'b1;
        tick();
        chk("idle_cnt", frame_cnt, 0);
        chk("idle_sync", frame_sync, 0);

        // Basic sequencing, ce every clock
        en = 1'b1;
        ce = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            c = i % 10;
            chk("basic_cnt", frame_cnt, c);
            chk("basic_num", frame_num, i / 10);
            chk("basic_sync", frame_sync, c == 0);
            chk_gates("basic", (c >= 2) && (c < 5), (c >= 6) && (c < 9));
            chk("basic_conflict", conflict, 0);
        end

        // Positive adjust requested at cnt 4
        cfg_if.frame_adj = 24'd3;
        cfg_if.adj_req   = 1'b1;
        tick();
        cfg_if.adj_req   = 1'b0;
        chk("adj_cnt5", frame_cnt, 5);
        chk("adj_pend_set", cfg_if.adj_pending, 1);
        ticks(4);
        chk("adj_cnt9", frame_cnt, 9);
        chk("adj_pend_hold", cfg_if.adj_pending, 1);
        tick();
        chk("adj_wrap_cnt", frame_cnt, 0);
        chk("adj_wrap_num", frame_num, 3);
        chk("adj_wrap_sync", frame_sync, 1);
        chk("adj_pend_clr", cfg_if.adj_pending, 0);
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("adj_long_cnt", frame_cnt, j);
            chk("adj_long_sync", frame_sync, 0);
        end
        tick();
        chk("adj_long_end_cnt", frame_cnt, 0);
        chk("adj_long_end_num", frame_num, 4);
        chk("adj_long_end_sync", frame_sync, 1);
        ticks(9);
        chk("adj_norm_cnt9", frame_cnt, 9);
        tick();
        chk("adj_norm_end_cnt", frame_cnt, 0);
        chk("adj_norm_end_num", frame_num, 5);

        // Negative adjust clamps the next frame to one sample
        cfg_if.frame_adj = 24'hFFFFEC;
        cfg_if.adj_req   = 1'b1;
        tick();
        cfg_if.adj_req   = 1'b0;
        chk("neg_cnt1", frame_cnt, 1);
        chk("neg_pend", cfg_if.adj_pending, 1);
        ticks(8);
        chk("neg_cnt9", frame_cnt, 9);
        tick();
        chk("neg_start_cnt", frame_cnt, 0);
        chk("neg_start_num", frame_num, 6);
        chk("neg_start_sync", frame_sync, 1);
        tick();
        chk("neg_l1_cnt", frame_cnt, 0);
        chk("neg_l1_num", frame_num, 7);
        chk("neg_l1_sync", frame_sync, 1);
        chk("neg_l1_pend", cfg_if.adj_pending, 0);
        tick();
        chk("neg_after_cnt", frame_cnt, 1);
        chk("neg_after_num", frame_num, 7);
        chk("neg_after_sync", frame_sync, 0);

        // Shadowing: frame_len written mid-frame
        ticks(2);
        chk("sh_cnt3", frame_cnt, 3);
        cfg_if.frame_len = 24'd20;
        ticks(6);
        chk("sh_cnt9", frame_cnt, 9);
        tick();
        chk("sh_wrap_cnt", frame_cnt, 0);
        chk("sh_wrap_num", frame_num, 8);
        for (int j = 1; j <= 19; j++) begin
            tick();
            chk("sh_long_cnt", frame_cnt, j);
        end
        tick();
        chk("sh_long_end_cnt", frame_cnt, 0);
        chk("sh_long_end_num", frame_num, 9);
        cfg_if.frame_len = 24'd10;
        ticks(19);
        chk("sh_restore_cnt19", frame_cnt, 19);
        tick();
        chk("sh_restore_cnt", frame_cnt, 0);
        chk("sh_restore_num", frame_num, 10);

        // ce every 4th clock
        txc = 0;
        for (int k = 1; k <= 10; k++) begin
            ce = 1'b0;
            for (int m = 0; m < 3; m++) begin
                tick();
                if (tx_en) txc++;
            end
            chk("ceg_hold_cnt", frame_cnt, k - 1);
            ce = 1'b1;
            tick();
            if (tx_en) txc++;
            chk("ceg_step_cnt", frame_cnt, k % 10);
        end
        chk("ceg_tx_clks", txc, 12);
        chk("ceg_num", frame_num, 11);
        chk("ceg_sync", frame_sync, 1);

        // Overlapping windows take effect next frame
        cfg_if.tstart = 24'd2;
        cfg_if.tend   = 24'd6;
        cfg_if.rstart = 24'd4;
        cfg_if.rend   = 24'd8;
        ticks(9);
        chk("ovl_pre_cnt9", frame_cnt, 9);
        chk("ovl_pre_conflict", conflict, 0);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("ovl_cnt", frame_cnt, j);
            chk_gates("ovl", (j >= 2) && (j < 6), (j >= 6) && (j < 8));
            chk("ovl_conflict", conflict, j >= 4);
        end

        // Empty TX window
        cfg_if.tend = 24'd2;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("empty_cnt", frame_cnt, j);
            chk_gates("empty", 1'b0, (j >= 4) && (j < 8));
            chk("empty_conflict", conflict, 1);
        end

        // Reset inside the TX window
        cfg_if.tstart = 24'd2;
        cfg_if.tend   = 24'd5;
        cfg_if.rstart = 24'd6;
        cfg_if.rend   = 24'd9;
        ticks(4);
        chk("mrst_pre_cnt", frame_cnt, 3);
        chk("mrst_pre_tx", tx_en, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_cnt", frame_cnt, 0);
        chk("mrst_num", frame_num, 0);
        chk_gates("mrst", 1'b0, 1'b0);
        chk("mrst_conflict", conflict, 0);
        tick();
        chk("mrst_reentry_sync", frame_sync, 1);
        chk("mrst_reentry_num", frame_num, 0);

        // Disable mid-frame with an adjust pending and ce low
        ticks(3);
        cfg_if.frame_adj = 24'd5;
        cfg_if.adj_req   = 1'b1;
        tick();
        cfg_if.adj_req   = 1'b0;
        chk("dis_pre_cnt", frame_cnt, 4);
        chk("dis_pre_tx", tx_en, 1);
        chk("dis_pre_pend", cfg_if.adj_pending, 1);
        en = 1'b0;
        ce = 1'b0;
        tick();
        chk("dis_cnt", frame_cnt, 0);
        chk("dis_num", frame_num, 0);
        chk("dis_sync", frame_sync, 0);
        chk_gates("dis", 1'b0, 1'b0);
        chk("dis_pend", cfg_if.adj_pending, 0);
        tick();
        chk("dis_idle_cnt", frame_cnt, 0);

        // Re-enable: waits for ce, then restarts at frame_num 0
        en = 1'b1;
        tick();
        chk("reen_wait_sync", frame_sync, 0);
        ce = 1'b1;
        tick();
        chk("reen_cnt", frame_cnt, 0);
        chk("reen_sync", frame_sync, 1);
        chk("reen_num", frame_num, 0);
        ticks(9);
        chk("reen_cnt9", frame_cnt, 9);
        tick();
        chk("reen_wrap_cnt", frame_cnt, 0);
        chk("reen_wrap_num", frame_num, 1);
        chk("reen_wrap_sync", frame_sync, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdd_frame_scheduler.md
Name: tdd_frame_scheduler

Overview:
- TDD frame sequencer in the Sclk (AD9361 sample) domain.
- Counts samples within a programmable frame and decodes the TX and RX windows.
- Drives the AXI2S stream gates (Ien/Oen qualifiers), the AD9361 Tx_Rx pin, PA_EN and RF_SW.
- Configuration and frame-timing adjust come from the AXI2S register space through quasi-static registers, shadowed at frame boundaries.

Parameters:
- CNT_W, 24, width of the sample counter and of all window/length fields.

Ports:
- clk  in  1  Sclk sample-domain clock
- rst_n  in  1  synchronous active-low reset
- ce  in  1  sample strobe; the counter advances only when ce=1
- en  in  1  TDD mode enable
- frame_len  in  CNT_W  frame length in samples
- tstart  in  CNT_W  TX window start, inclusive
- tend  in  CNT_W  TX window end, exclusive
- rstart  in  CNT_W  RX window start, inclusive
- rend  in  CNT_W  RX window end, exclusive
- frame_adj  in  CNT_W  signed one-shot length correction
- adj_req  in  1  single-cycle pulse requesting frame_adj
- adj_pending  out  1  high while an adjust is waiting for the next boundary
- frame_cnt  out  CNT_W  current sample index in the frame
- frame_num  out  32  frames started since the last entry to RUN
- frame_sync  out  1  one-clk pulse at each frame start
- tx_en  out  1  TX stream gate
- rx_en  out  1  RX stream gate
- tx_rx  out  1  AD9361 Tx_Rx pin
- pa_en  out  1  PA enable
- rf_sw  out  1  RF switch; 1 = TX path
- conflict  out  1  sticky flag: TX/RX windows overlapped

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0; state IDLE; shadow registers 0; adj_pending cleared. Applies mid-frame too, with no drain.
- FSM states: IDLE, RUN.
- IDLE:
  - frame_cnt=0; all gates 0; no frame_sync.
  - Enters RUN on the first clk with en=1 and ce=1.
  - On that edge: frame_cnt=0, frame_sync=1, frame_num=0, shadows loaded.
- RUN:
  - On each ce=1, frame_cnt increments.
  - When frame_cnt = L-1 it wraps to 0. On the wrap edge: frame_sync=1, frame_num+1 (mod 2^32), shadows reloaded.
  - ce=0 holds all state.
  - en=0 returns to IDLE at the next clk regardless of ce; all outputs are 0 on that edge and adj_pending is cleared.
- Shadowing:
  - frame_len, tstart, tend, rstart and rend are sampled only at frame start.
  - Mid-frame register writes take effect in the next frame.
- Effective length: L = frame_len_sh + adj_sh, signed arithmetic in CNT_W+1 bits.
  - Results below 1 clamp to 1. With L=1, frame_sync fires on every ce.
- Adjust:
  - adj_req latches frame_adj and sets adj_pending. A second adj_req while pending overwrites the latched value.
  - At the next frame start the latched value becomes adj_sh for that frame only and adj_pending clears. Later frames use adj_sh=0.
  - adj_req on the same clk as a frame start is taken by the frame after.
- Window decode, from the next frame_cnt and the shadow values:
  - txw = (tstart_sh <= cnt < tend_sh); rxw = (rstart_sh <= cnt < rend_sh).
  - tend<=tstart or rend<=rstart gives an empty window.
  - Windows beyond L never fire.
- Output registration: all outputs are registered on the same edge as frame_cnt, so there is zero latency relative to frame_cnt.
- Gate mapping:
  - tx_en = tx_rx = pa_en = rf_sw = txw.
  - rx_en = rxw & ~txw: TX has priority on overlap.
- conflict sets when txw & rxw; clears only on reset or IDLE entry.

Test Plan:
- Basic sequencing:
  - Stimulus: frame_len=10, tstart=2, tend=5, rstart=6, rend=9, ce every clk, en=1.
  - Required: frame_cnt 0..9 repeating; tx_en high at cnt 2-4; rx_en high at cnt 6-8; frame_sync at cnt 0; frame_num increments every 10 clks; conflict=0.
- ce gating:
  - Stimulus: same config, ce every 4th clk.
  - Required: outputs change only on ce edges; a frame spans 40 clks; tx_en is high for 12 clks.
- Adjust:
  - Stimulus: adj_req with frame_adj=+3 at cnt 4.
  - Required: adj_pending high until the next wrap; that frame runs 13 samples; the following frame runs 10.
  - Stimulus: frame_adj=-20 (negative clamp case).
  - Required: L=1 for one frame.
- Overlap and empty windows:
  - Stimulus: tstart=2, tend=6, rstart=4, rend=8.
  - Required: rx_en only at cnt 6-7; conflict goes to 1 and stays sticky.
  - Stimulus: tend=tstart.
  - Required: tx_en never asserts.
- Shadowing:
  - Stimulus: write frame_len=20 at cnt 3.
  - Required: the current frame still wraps at 9; the next frame wraps at 19.
- Reset and disable mid-frame:
  - Stimulus: rst_n=0 at cnt 3 (inside TX).
  - Required: tx_en, pa_en, tx_rx and frame_cnt read 0 next clk.
  - Stimulus: en=0.
  - Required: same all-zero result on the next clk; re-enabling restarts at frame_num=0.
